serial_subtractor: RTL

//   Bit-serial A - B subtractor built around a single full-subtractor cell and a registered borrow.
//   - Operands load in parallel; one bit is processed per clock, LSB first.
//   - A start/busy/done handshake frames each operation.
//   - Difference and final borrow are presented in parallel and held until the next completion.
//   - Sequential counterpart to the full-adder/full-subtractor cells; reused by the ALU labs.

---
 rtl/serial_subtractor.sv | 90 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B subtractor, one full-subtractor cell plus borrow flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [WIDTH-1:0] d_next;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             a_bit;
    logic             b_bit;
    logic             d;
    logic             bout;
    logic             last_bit;

    assign a_bit    = a_sr[0];
    assign b_bit    = b_sr[0];
    assign d        = a_bit ^ b_bit ^ bin;
    assign bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // New difference bit enters at the MSB; a 1-bit build has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign d_next = d;
        end else begin : g_wide
            assign d_next = {d, d_sr[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            cnt        <= '0;
            bin        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= d_next;
                    bin  <= bout;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        state      <= DONE;
                        diff       <= d_next;
                        borrow_out <= bout;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation; DONE falls back to IDLE otherwise.
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        d_sr  <= '0;
                        bin   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
